// File: rtl/vec_accumulator.sv
// Sequential dot-product reduction: sums N unsigned W-bit elements into one
// OW-bit result with valid/ready handshakes on both the input and output sides.
module vec_accumulator #(
   parameter  int W  = 16,
   parameter  int N  = 8,
   localparam int OW = W + $clog2(N)
) (
   input  logic          I_CLK,
   input  logic          I_RST_N,
   input  logic          I_CLEAR,
   input  logic          I_VALID,
   output logic          O_READY,
   input  logic [W-1:0]  I_DATA,
   output logic          O_VALID,
   input  logic          I_READY,
   output logic [OW-1:0] O_SUM
);

   localparam int GW = OW - W;
   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACC,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [OW-1:0] acc_q,   acc_d;
   logic [OW-1:0] sum_q,   sum_d;
   logic          valid_q, valid_d;

   logic          accept;
   logic [W:0]    lo_sum;
   logic [GW-1:0] hi_sum;
   logic [OW-1:0] acc_next;

   // W-bit ripple add on the low part; its carry-out feeds the guard bits.
   always_comb begin
      lo_sum   = {1'b0, acc_q[W-1:0]} + {1'b0, I_DATA};
      hi_sum   = acc_q[OW-1:W] + GW'(lo_sum[W]);
      acc_next = {hi_sum, lo_sum[W-1:0]};
   end

   assign O_READY = (state_q != S_DONE);
   assign accept  = I_VALID && O_READY && !I_CLEAR;

   // NOTE: every variable gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      valid_d = valid_q;

      if (I_CLEAR) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         valid_d = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  acc_d   = {{GW{1'b0}}, I_DATA};
                  cnt_d   = CW'(1);
                  state_d = S_ACC;
               end
            end
            S_ACC: begin
               if (accept) begin
                  acc_d = acc_next;
                  cnt_d = cnt_q + CW'(1);
                  if (cnt_q == CW'(N - 1)) begin
                     sum_d   = acc_next;
                     valid_d = 1'b1;
                     state_d = S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (I_READY) begin
                  valid_d = 1'b0;
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         valid_q <= valid_d;
      end
   end

   assign O_VALID = valid_q;
   assign O_SUM   = sum_q;

endmodule
